// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 4-bit-opcode processor.
// Sequences fetch / decode / execute / memory / writeback and drives the
// shared-ALU and unified-memory datapath controls. Memory states wait on
// mem_ready and fall into a sticky ERROR state if the wait runs too long.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PC_WRITE,
  output logic       IR_WRITE,
  output logic       I_OR_D,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic       REG_WRITE,
  output logic       REG_DEST,
  output logic       MEM_TO_REG,
  output logic       ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [2:0] ALU_control,
  output logic [1:0] PC_SOURCE,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_LW  = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ERROR  = 4'd15
  } state_t;

  // Counter wide enough to hold MEM_TIMEOUT itself.
  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_mem_err;
  logic            w_mem_state;
  logic            w_limit;

  assign state   = r_state;
  assign mem_err = r_mem_err;

  // States that talk to memory and are subject to the wait timeout.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

  // This waiting cycle is the last one allowed before giving up.
  assign w_limit = (MEM_TIMEOUT != 32'd0) && ((32'(r_cnt) + 32'd1) == MEM_TIMEOUT);

  // Next-state selection from current state, opcode and memory handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)    w_next = S_DECODE;
        else if (w_limit) w_next = S_ERROR;
        else              w_next = S_FETCH;
      end
      S_DECODE: begin
        if (!opcode[3]) begin
          w_next = S_EXEC_R;
        end else begin
          case (opcode)
            4'b1000, 4'b1010: w_next = S_ADDR;
            4'b1110:          w_next = S_BRANCH;
            4'b1111:          w_next = S_JUMP;
            default:          w_next = S_FETCH;
          endcase
        end
      end
      S_EXEC_R: w_next = S_WB_R;
      S_WB_R:   w_next = S_FETCH;
      S_ADDR: begin
        if (opcode == 4'b1000)      w_next = S_MEM_RD;
        else if (opcode == 4'b1010) w_next = S_MEM_WR;
        else                        w_next = S_FETCH;
      end
      S_MEM_RD: begin
        if (mem_ready)    w_next = S_WB_LW;
        else if (w_limit) w_next = S_ERROR;
        else              w_next = S_MEM_RD;
      end
      S_WB_LW: w_next = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)    w_next = S_FETCH;
        else if (w_limit) w_next = S_ERROR;
        else              w_next = S_MEM_WR;
      end
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_FETCH;
    endcase
  end

  // State register, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_mem_state && !mem_ready && (MEM_TIMEOUT != 32'd0)) begin
        r_cnt <= r_cnt + CW'(1'b1);
      end else begin
        r_cnt <= '0;
      end
      if (w_next == S_ERROR) begin
        r_mem_err <= 1'b1;
      end else begin
        r_mem_err <= r_mem_err;
      end
    end
  end

  // Datapath controls decoded from the state register; everything is held
  // low while rst_n is asserted so an aborted instruction leaves no strobe.
  always_comb begin
    PC_WRITE    = 1'b0;
    IR_WRITE    = 1'b0;
    I_OR_D      = 1'b0;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    REG_WRITE   = 1'b0;
    REG_DEST    = 1'b0;
    MEM_TO_REG  = 1'b0;
    ALU_SRC_A   = 1'b0;
    ALU_SRC_B   = 2'b00;
    ALU_control = 3'b000;
    PC_SOURCE   = 2'b00;
    instr_done  = 1'b0;
    if (!rst_n) begin
      PC_WRITE = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          MEM_READ    = 1'b1;
          ALU_SRC_B   = 2'b01;
          ALU_control = 3'b010;
          IR_WRITE    = mem_ready;
          PC_WRITE    = mem_ready;
        end
        S_DECODE: begin
          ALU_SRC_B   = 2'b10;
          ALU_control = 3'b010;
          // NOP opcodes finish here; everything else has a later phase.
          instr_done  = opcode[3] && (opcode != 4'b1000) && (opcode != 4'b1010)
                        && (opcode != 4'b1110) && (opcode != 4'b1111);
        end
        S_EXEC_R: begin
          ALU_SRC_A   = 1'b1;
          ALU_control = opcode[2:0];
        end
        S_WB_R: begin
          REG_WRITE  = 1'b1;
          REG_DEST   = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDR: begin
          ALU_SRC_A   = 1'b1;
          ALU_SRC_B   = 2'b10;
          ALU_control = 3'b010;
        end
        S_MEM_RD: begin
          MEM_READ = 1'b1;
          I_OR_D   = 1'b1;
        end
        S_WB_LW: begin
          REG_WRITE  = 1'b1;
          MEM_TO_REG = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          MEM_WRITE  = 1'b1;
          I_OR_D     = 1'b1;
          instr_done = mem_ready;
        end
        S_BRANCH: begin
          ALU_SRC_A   = 1'b1;
          ALU_control = 3'b110;
          PC_SOURCE   = 2'b01;
          PC_WRITE    = ~zero;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PC_SOURCE  = 2'b10;
          PC_WRITE   = 1'b1;
          instr_done = 1'b1;
        end
        S_ERROR: begin
          PC_WRITE = 1'b0;
        end
        default: begin
          PC_WRITE = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into the list of
// cycles it should take (with chosen memory wait counts), then replayed
// against the DUT cycle by cycle comparing state and every control output.
module tb_multicycle_control;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1, ST_EXEC_R = 4'd2,
                         ST_WB_R  = 4'd3,  ST_ADDR   = 4'd4, ST_MEM_RD = 4'd5,
                         ST_WB_LW = 4'd6,  ST_MEM_WR = 4'd7, ST_BRANCH = 4'd8,
                         ST_JUMP  = 4'd9,  ST_ERROR  = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PC_WRITE, IR_WRITE, I_OR_D, MEM_READ, MEM_WRITE, REG_WRITE;
  logic       REG_DEST, MEM_TO_REG, ALU_SRC_A, instr_done, mem_err;
  logic [1:0] ALU_SRC_B, PC_SOURCE;
  logic [2:0] ALU_control;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int stepno = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic        mr;
    logic [17:0] v;
  } step_t;
  step_t q[$];

  multicycle_control #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PC_WRITE(PC_WRITE), .IR_WRITE(IR_WRITE), .I_OR_D(I_OR_D), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE), .REG_WRITE(REG_WRITE), .REG_DEST(REG_DEST),
    .MEM_TO_REG(MEM_TO_REG), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
    .ALU_control(ALU_control), .PC_SOURCE(PC_SOURCE), .state(state),
    .instr_done(instr_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  logic [17:0] w_obs;
  assign w_obs = {PC_WRITE, IR_WRITE, I_OR_D, MEM_READ, MEM_WRITE, REG_WRITE, REG_DEST,
                  MEM_TO_REG, ALU_SRC_A, ALU_SRC_B, ALU_control, PC_SOURCE, instr_done, mem_err};

  function automatic logic [17:0] ov(
    input logic pcw, input logic irw, input logic iord, input logic mrd, input logic mwr,
    input logic rw, input logic rd, input logic m2r, input logic asa, input logic [1:0] asb,
    input logic [2:0] alu, input logic [1:0] pcs, input logic done, input logic err);
    return {pcw, irw, iord, mrd, mwr, rw, rd, m2r, asa, asb, alu, pcs, done, err};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (step %0d, opcode %b): observed %h expected %h", tag, stepno, opcode, obs, exp);
    end
  endtask

  task automatic add(input logic [3:0] st, input logic mr, input logic [17:0] v);
    q.push_back('{st: st, mr: mr, v: v});
  endtask

  task automatic add_error();
    for (int i = 0; i < 4; i++) add(ST_ERROR, rnd_bit(), ov(0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1));
  endtask

  // Expand one instruction into its expected cycles. wf/wm are the number of
  // not-ready cycles in the fetch and data-memory phases; 16 or more means the
  // memory never answers and the controller should give up.
  task automatic build(input logic [3:0] op, input int wf, input int wm);
    bit is_r, is_lw, is_sw, is_bne, is_j, is_nop;
    logic [17:0] v_fetch_wait, v_fetch_go;
    is_r   = (op < 4'd8);
    is_lw  = (op == 4'b1000);
    is_sw  = (op == 4'b1010);
    is_bne = (op == 4'b1110);
    is_j   = (op == 4'b1111);
    is_nop = !(is_r || is_lw || is_sw || is_bne || is_j);
    v_fetch_wait = ov(0,0,0,1,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);
    v_fetch_go   = ov(1,1,0,1,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);
    for (int i = 0; i < wf && i < 16; i++) add(ST_FETCH, 1'b0, v_fetch_wait);
    if (wf >= 16) begin add_error(); return; end
    add(ST_FETCH, 1'b1, v_fetch_go);
    add(ST_DECODE, rnd_bit(), ov(0,0,0,0,0,0,0,0,0,2'b10,3'b010,2'b00,is_nop,0));
    if (is_r) begin
      add(ST_EXEC_R, rnd_bit(), ov(0,0,0,0,0,0,0,0,1,2'b00,op[2:0],2'b00,0,0));
      add(ST_WB_R,   rnd_bit(), ov(0,0,0,0,0,1,1,0,0,2'b00,3'b000,2'b00,1,0));
    end else if (is_lw || is_sw) begin
      add(ST_ADDR, rnd_bit(), ov(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
      for (int i = 0; i < wm && i < 16; i++)
        add(is_lw ? ST_MEM_RD : ST_MEM_WR, 1'b0, ov(0,0,1,is_lw,is_sw,0,0,0,0,2'b00,3'b000,2'b00,0,0));
      if (wm >= 16) begin add_error(); return; end
      if (is_lw) begin
        add(ST_MEM_RD, 1'b1, ov(0,0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0));
        add(ST_WB_LW, rnd_bit(), ov(0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,1,0));
      end else begin
        add(ST_MEM_WR, 1'b1, ov(0,0,1,0,1,0,0,0,0,2'b00,3'b000,2'b00,1,0));
      end
    end else if (is_bne) begin
      add(ST_BRANCH, rnd_bit(), ov(~zero,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));
    end else if (is_j) begin
      add(ST_JUMP, rnd_bit(), ov(1,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0));
    end
  endtask

  // Replay queued cycles: inputs at the falling edge, check 1 ns later.
  task automatic run();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      stepno++;
      mem_ready = s.mr;
      #1;
      chk("state", {14'd0, state}, {14'd0, s.st});
      chk("outputs", w_obs, s.v);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("reset_state", {14'd0, state}, 18'd0);
    chk("reset_outputs", w_obs, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mem_ready = 1'b1;
    #3;
    chk("por_state", {14'd0, state}, 18'd0);
    chk("por_outputs", w_obs, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;

    opcode = 4'b0011; build(4'b0011, 0, 0); run();            // R-type
    opcode = 4'b1000; build(4'b1000, 0, 3); run();            // LW, 3 waits
    zero = 1'b0; opcode = 4'b1110; build(4'b1110, 0, 0); run();
    zero = 1'b1; opcode = 4'b1110; build(4'b1110, 0, 0); run();
    opcode = 4'b1010; build(4'b1010, 0, 0); run();            // SW
    opcode = 4'b1111; build(4'b1111, 0, 0); run();            // J
    opcode = 4'b1000; build(4'b1000, 15, 15); run();          // ready on the limit cycle
    opcode = 4'b1010; build(4'b1010, 2, 15); run();

    for (int n = 0; n < 60; n++) begin
      opcode = 4'($urandom_range(15, 0));
      zero   = rnd_bit();
      build(opcode, int'($urandom_range(4, 0)), int'($urandom_range(4, 0)));
      run();
    end

    opcode = 4'b0101; build(4'b0101, 16, 0); run();           // fetch timeout
    do_reset();
    opcode = 4'b1000; build(4'b1000, 1, 16); run();           // MEM_RD timeout
    do_reset();
    opcode = 4'b1010; build(4'b1010, 0, 16); run();           // MEM_WR timeout
    do_reset();

    // Reset in the middle of a store that is still waiting.
    opcode = 4'b1010;
    add(ST_FETCH,  1'b1, ov(1,1,0,1,0,0,0,0,0,2'b01,3'b010,2'b00,0,0));
    add(ST_DECODE, 1'b0, ov(0,0,0,0,0,0,0,0,0,2'b10,3'b010,2'b00,0,0));
    add(ST_ADDR,   1'b0, ov(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
    add(ST_MEM_WR, 1'b0, ov(0,0,1,0,1,0,0,0,0,2'b00,3'b000,2'b00,0,0));
    add(ST_MEM_WR, 1'b0, ov(0,0,1,0,1,0,0,0,0,2'b00,3'b000,2'b00,0,0));
    run();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", {14'd0, state}, 18'd0);
    chk("abort_memwrite", {17'd0, MEM_WRITE}, 18'd0);
    chk("abort_outputs", w_obs, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 4'b1001; build(4'b1001, 0, 0); run();            // NOP

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
